// File: rtl/video_timing_ctrl.sv
// -----------------------------------------------------------------------------
// video_timing_ctrl
//
// Raster timing generator. Free-running horizontal/vertical beam counters
// advance on pix_ce; registered sync/blank/border strobes are derived from the
// counter values one pix_ce cycle later. Timing comes from an "active" config
// set that is reloaded from a software-written "shadow" set only when the
// beam wraps to (0,0), so a frame is never drawn with mixed timing.
//
// Optional feature (compile-time macro VIDEO_TIMING_CTRL_LINE_IRQ_EN):
//   line-compare interrupt pulse on irq. Without the macro irq is tied low and
//   irq_line is ignored.
//
// Ports:
//   clk          sole clock
//   rst          synchronous active-high reset (overrides pix_ce and cfg_we)
//   pix_ce       pixel clock enable
//   cfg_we       shadow config write strobe
//   cfg_h        {h_sync_end, h_sync_start, h_bdr_end, h_disp}
//   cfg_v        {v_sync_end, v_sync_start, v_bdr_end, v_disp}
//   cfg_total    {v_total, h_total}
//   cfg_pol      {vsync_pol, hsync_pol}, 1 = active-high
//   irq_line     line-compare value (sampled live)
//   hsync, vsync, blank, border   registered timing strobes
//   hctr, vctr   current beam position
//   frame_start  one-clk pulse when the beam becomes (0,0)
//   irq          one-clk pulse when a line matching irq_line begins
// -----------------------------------------------------------------------------
module video_timing_ctrl #(
   parameter int unsigned HBITS = 12,
   parameter int unsigned VBITS = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pix_ce,
   input  logic                   cfg_we,
   input  logic [4*HBITS-1:0]     cfg_h,
   input  logic [4*VBITS-1:0]     cfg_v,
   input  logic [HBITS+VBITS-1:0] cfg_total,
   input  logic [1:0]             cfg_pol,
   input  logic [VBITS-1:0]       irq_line,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   blank,
   output logic                   border,
   output logic [HBITS-1:0]       hctr,
   output logic [VBITS-1:0]       vctr,
   output logic                   frame_start,
   output logic                   irq
);

   // 640x480 reset timing
   localparam logic [4*HBITS-1:0] def_h =
      {HBITS'(752), HBITS'(656), HBITS'(648), HBITS'(640)};
   localparam logic [4*VBITS-1:0] def_v =
      {VBITS'(492), VBITS'(490), VBITS'(485), VBITS'(480)};
   localparam logic [HBITS+VBITS-1:0] def_total = {VBITS'(525), HBITS'(800)};
   localparam logic [1:0] def_pol = 2'b00;

   // ---------------------------------------------------------------------------
   // Config registers
   // ---------------------------------------------------------------------------
   logic [4*HBITS-1:0]     sh_h_q,     act_h_q;
   logic [4*VBITS-1:0]     sh_v_q,     act_v_q;
   logic [HBITS+VBITS-1:0] sh_total_q, act_total_q;
   logic [1:0]             sh_pol_q,   act_pol_q;

   // Active field decode
   logic [HBITS-1:0] h_disp, h_bdr_end, h_sync_start, h_sync_end, h_total;
   logic [VBITS-1:0] v_disp, v_bdr_end, v_sync_start, v_sync_end, v_total;

   assign h_disp       = act_h_q[0*HBITS +: HBITS];
   assign h_bdr_end    = act_h_q[1*HBITS +: HBITS];
   assign h_sync_start = act_h_q[2*HBITS +: HBITS];
   assign h_sync_end   = act_h_q[3*HBITS +: HBITS];
   assign h_total      = act_total_q[0 +: HBITS];

   assign v_disp       = act_v_q[0*VBITS +: VBITS];
   assign v_bdr_end    = act_v_q[1*VBITS +: VBITS];
   assign v_sync_start = act_v_q[2*VBITS +: VBITS];
   assign v_sync_end   = act_v_q[3*VBITS +: VBITS];
   assign v_total      = act_total_q[HBITS +: VBITS];

   // ---------------------------------------------------------------------------
   // Beam counters
   // ---------------------------------------------------------------------------
   logic [HBITS-1:0] hctr_q, hctr_d;
   logic [VBITS-1:0] vctr_q, vctr_d;
   logic [HBITS-1:0] h_last;
   logic [VBITS-1:0] v_last;
   logic             h_wrap, v_wrap, frame_wrap;

   // Totals below 2 are clamped to 2 so the counters always move.
   assign h_last = (h_total < HBITS'(2)) ? HBITS'(1) : h_total - HBITS'(1);
   assign v_last = (v_total < VBITS'(2)) ? VBITS'(1) : v_total - VBITS'(1);

   // Active timing only changes at (0,0), so the counters cannot overshoot;
   // >= still guarantees recovery if they ever did.
   assign h_wrap     = (hctr_q >= h_last);
   assign v_wrap     = (vctr_q >= v_last);
   assign frame_wrap = h_wrap && v_wrap;

   always_comb begin
      hctr_d = hctr_q + HBITS'(1);
      vctr_d = vctr_q;
      if (h_wrap) begin
         hctr_d = '0;
         vctr_d = v_wrap ? '0 : vctr_q + VBITS'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Timing strobes, decoded from the current (pre-increment) position
   // ---------------------------------------------------------------------------
   logic in_disp, in_bdr, in_hsync, in_vsync;
   logic hsync_d, vsync_d, blank_d, border_d;

   always_comb begin
      in_disp  = (hctr_q < h_disp) && (vctr_q < v_disp);
      in_bdr   = (hctr_q < h_bdr_end) && (vctr_q < v_bdr_end) && !in_disp;
      in_hsync = (hctr_q >= h_sync_start) && (hctr_q < h_sync_end);
      in_vsync = (vctr_q >= v_sync_start) && (vctr_q < v_sync_end);
      hsync_d  = in_hsync ? act_pol_q[0] : ~act_pol_q[0];
      vsync_d  = in_vsync ? act_pol_q[1] : ~act_pol_q[1];
      blank_d  = !in_disp;
      border_d = in_bdr;
   end

   logic hsync_q, vsync_q, blank_q, border_q, frame_start_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_h_q        <= def_h;
         sh_v_q        <= def_v;
         sh_total_q    <= def_total;
         sh_pol_q      <= def_pol;
         act_h_q       <= def_h;
         act_v_q       <= def_v;
         act_total_q   <= def_total;
         act_pol_q     <= def_pol;
         hctr_q        <= '0;
         vctr_q        <= '0;
         hsync_q       <= ~def_pol[0];
         vsync_q       <= ~def_pol[1];
         blank_q       <= 1'b1;
         border_q      <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= 1'b0;
         if (cfg_we) begin
            sh_h_q     <= cfg_h;
            sh_v_q     <= cfg_v;
            sh_total_q <= cfg_total;
            sh_pol_q   <= cfg_pol;
         end
         if (pix_ce) begin
            hctr_q        <= hctr_d;
            vctr_q        <= vctr_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            border_q      <= border_d;
            frame_start_q <= frame_wrap;
            // Non-blocking semantics: a cfg_we on this same edge is not yet
            // visible, so the previous shadow contents are taken.
            if (frame_wrap) begin
               act_h_q     <= sh_h_q;
               act_v_q     <= sh_v_q;
               act_total_q <= sh_total_q;
               act_pol_q   <= sh_pol_q;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Optional line-compare interrupt
   // ---------------------------------------------------------------------------
`ifdef VIDEO_TIMING_CTRL_LINE_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= pix_ce && h_wrap && (vctr_d == irq_line);
      end
   end

   assign irq = irq_q;
`else
   logic unused_irq_line;
   assign unused_irq_line = ^irq_line;
   assign irq = 1'b0;
`endif

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank       = blank_q;
   assign border      = border_q;
   assign hctr        = hctr_q;
   assign vctr        = vctr_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_video_timing_ctrl
//
// Self-checking bench for video_timing_ctrl. A behavioural raster model
// computes the expected outputs for every clock; they are queued when the
// stimulus for that edge is applied and compared after the edge. Frame
// periods are measured from the DUT frame_start pulses and checked against
// constants derived from the programmed timing.
// -----------------------------------------------------------------------------
module tb_video_timing_ctrl;

   localparam int unsigned HB = 12;
   localparam int unsigned VB = 12;

   typedef struct packed {
      logic [11:0] hd, hb, hss, hse, ht;
      logic [11:0] vd, vb, vss, vse, vt;
      logic [1:0]  pol;
   } cfg_t;

   typedef struct packed {
      logic [11:0] h, v;
      logic        hs, vs, bl, bd, fs, irq;
   } obs_t;

   typedef struct packed {
      logic chk;
      obs_t o;
   } want_t;

   logic              clk = 1'b0;
   logic              rst, pix_ce, cfg_we;
   logic [4*HB-1:0]   cfg_h;
   logic [4*VB-1:0]   cfg_v;
   logic [HB+VB-1:0]  cfg_total;
   logic [1:0]        cfg_pol;
   logic [VB-1:0]     irq_line;
   logic              hsync, vsync, blank, border, frame_start, irq;
   logic [HB-1:0]     hctr;
   logic [VB-1:0]     vctr;

   cfg_t drv;

   assign cfg_h     = {drv.hse, drv.hss, drv.hb, drv.hd};
   assign cfg_v     = {drv.vse, drv.vss, drv.vb, drv.vd};
   assign cfg_total = {drv.vt, drv.ht};
   assign cfg_pol   = drv.pol;

   always #5 clk = ~clk;

   video_timing_ctrl #(
      .HBITS (HB),
      .VBITS (VB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pix_ce      (pix_ce),
      .cfg_we      (cfg_we),
      .cfg_h       (cfg_h),
      .cfg_v       (cfg_v),
      .cfg_total   (cfg_total),
      .cfg_pol     (cfg_pol),
      .irq_line    (irq_line),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank       (blank),
      .border      (border),
      .hctr        (hctr),
      .vctr        (vctr),
      .frame_start (frame_start),
      .irq         (irq)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, want, $time);
      end
   endtask

   function automatic cfg_t make_cfg(input int hd, hb, hss, hse, ht,
                                     input int vd, vb, vss, vse, vt, input int pol);
      cfg_t c;
      c.hd  = 12'(hd);  c.hb  = 12'(hb);  c.hss = 12'(hss); c.hse = 12'(hse); c.ht = 12'(ht);
      c.vd  = 12'(vd);  c.vb  = 12'(vb);  c.vss = 12'(vss); c.vse = 12'(vse); c.vt = 12'(vt);
      c.pol = 2'(pol);
      return c;
   endfunction

   function automatic int clamp2(input logic [11:0] t);
      return (int'(t) < 2) ? 2 : int'(t);
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   cfg_t defc, m_act, m_sh;
   int   m_h, m_v;
   logic m_hs, m_vs, m_bl, m_bd, m_fs, m_irq;
   int   irq_seen = 0;

   task automatic model_step();
      bit disp;
      if (rst) begin
         m_h = 0; m_v = 0; m_act = defc; m_sh = defc;
         m_hs = 1'b1; m_vs = 1'b1; m_bl = 1'b1; m_bd = 1'b0; m_fs = 1'b0; m_irq = 1'b0;
      end else begin
         m_fs  = 1'b0;
         m_irq = 1'b0;
         if (pix_ce) begin
            disp = (m_h < int'(m_act.hd)) && (m_v < int'(m_act.vd));
            m_bl = !disp;
            m_bd = !disp && (m_h < int'(m_act.hb)) && (m_v < int'(m_act.vb));
            m_hs = (m_h >= int'(m_act.hss) && m_h < int'(m_act.hse)) ? m_act.pol[0] : !m_act.pol[0];
            m_vs = (m_v >= int'(m_act.vss) && m_v < int'(m_act.vse)) ? m_act.pol[1] : !m_act.pol[1];
            if (m_h == clamp2(m_act.ht) - 1) begin
               m_h = 0;
               if (m_v == clamp2(m_act.vt) - 1) begin
                  m_v   = 0;
                  m_act = m_sh;
                  m_fs  = 1'b1;
               end else begin
                  m_v++;
               end
`ifdef VIDEO_TIMING_CTRL_LINE_IRQ_EN
               if (m_v == int'(irq_line)) m_irq = 1'b1;
`endif
            end else begin
               m_h++;
            end
         end
         if (cfg_we) m_sh = drv;
      end
   endtask

   want_t sb[$];

   // One clock: model predicts, expectation queued, DUT sampled after the edge.
   task automatic tick();
      want_t w;
      want_t got;
      obs_t  o;
      model_step();
      w.o   = '{h: 12'(m_h), v: 12'(m_v), hs: m_hs, vs: m_vs, bl: m_bl, bd: m_bd,
                fs: m_fs, irq: m_irq};
      w.chk = rst || (m_v < 2) || (m_v == 100) || (m_v == 200) ||
              (m_v >= 488 && m_v <= 493) || (m_v >= 523) || (m_act.ht != 12'd800);
      sb.push_back(w);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      o   = {hctr, vctr, hsync, vsync, blank, border, frame_start, irq};
      if (irq === 1'b1) irq_seen++;
      if (got.chk) check_eq("outputs {h,v,hs,vs,bl,bd,fs,irq}", 64'(o), 64'(got.o));
   endtask

   task automatic run_until_fs(input bit alt, input int limit, output int n);
      n = 0;
      do begin
         pix_ce = alt ? (n % 2 == 1) : 1'b1;
         tick();
         n++;
      end while (frame_start !== 1'b1 && n < limit);
      pix_ce = 1'b1;
   endtask

   task automatic run_until_pos(input int th, input int tv, input int limit, output int n);
      n = 0;
      while (!(m_h == th && m_v == tv) && n < limit) begin
         tick();
         n++;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      cfg_t cfg1, cfg2, cfg3, junk;
      int   n, n2, irq_want;

      defc = make_cfg(640, 648, 656, 752, 800, 480, 485, 490, 492, 525, 0);
      cfg1 = make_cfg(80, 84, 88, 92, 100, 6, 7, 8, 9, 10, 1);
      cfg2 = make_cfg(40, 42, 44, 48, 50, 2, 3, 3, 4, 4, 3);
      cfg3 = make_cfg(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2);
      junk = make_cfg(5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 3);

      // Reset with a competing cfg_we that must be discarded.
      drv = junk; rst = 1'b1; cfg_we = 1'b1; pix_ce = 1'b1; irq_line = 12'd479;
      tick();
      tick();
      check_eq("rst_blank", 64'(blank), 64'(1));
      check_eq("rst_hsync", 64'(hsync), 64'(1));
      rst = 1'b0; cfg_we = 1'b0;

      // Default frame; a mid-frame write at line 200 must not disturb it.
      irq_seen = 0;
      run_until_pos(0, 200, 200000, n);
      drv = cfg1; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      run_until_fs(1'b0, 300000, n2);
      check_eq("frame0_period", 64'(n + 1 + n2), 64'(420000));
`ifdef VIDEO_TIMING_CTRL_LINE_IRQ_EN
      irq_want = 1;
`else
      irq_want = 0;
`endif
      check_eq("frame0_irq_count", 64'(irq_seen), 64'(irq_want));

      // cfg1 frame; write cfg2 exactly on the wrap edge.
      irq_line = 12'd5;
      run_until_pos(99, 9, 2000, n);
      drv = cfg2; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      check_eq("frame1_period", 64'(n + 1), 64'(1000));
      check_eq("wrap_frame_start", 64'(frame_start), 64'(1));

      // Coincident write is deferred: one more cfg1 frame, then cfg2.
      run_until_fs(1'b0, 5000, n);
      check_eq("frame2_period", 64'(n), 64'(1000));
      run_until_fs(1'b0, 5000, n);
      check_eq("frame3_period", 64'(n), 64'(200));

      // pix_ce every other clock doubles the period in clocks.
      run_until_fs(1'b1, 5000, n);
      check_eq("frame4_alt_period", 64'(n), 64'(400));

      // Totals below 2 clamp to a 2x2 raster.
      drv = cfg3; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      run_until_fs(1'b0, 5000, n);
      check_eq("frame5_period", 64'(n + 1), 64'(200));
      run_until_fs(1'b0, 100, n);
      check_eq("clamp_period_a", 64'(n), 64'(4));
      run_until_fs(1'b0, 100, n);
      check_eq("clamp_period_b", 64'(n), 64'(4));

      // Mid-frame reset, then run two default lines.
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("midrst_hctr", 64'(hctr), 64'(0));
      check_eq("midrst_vsync", 64'(vsync), 64'(1));
      check_eq("midrst_fs", 64'(frame_start), 64'(0));
      for (int i = 0; i < 1700; i++) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/video_timing_ctrl.md
VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 SHALL have parameter HBITS, default 12, horizontal counter/config width.
REQ-002 SHALL have parameter VBITS, default 12, vertical counter/config width.
REQ-003 SHALL have port clk  input  1  sole clock.
REQ-004 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-005 SHALL have port pix_ce  input  1  pixel clock enable; counters/outputs advance only when high.
REQ-006 SHALL have port cfg_we  input  1  write strobe for the shadow config set.
REQ-007 SHALL have port cfg_h  input  4*HBITS  {h_sync_end, h_sync_start, h_bdr_end, h_disp}, LSB field first.
REQ-008 SHALL have port cfg_v  input  4*VBITS  {v_sync_end, v_sync_start, v_bdr_end, v_disp}, LSB field first.
REQ-009 SHALL have port cfg_total  input  HBITS+VBITS  {v_total, h_total}.
REQ-010 SHALL have port cfg_pol  input  2  {vsync_pol, hsync_pol}; 1 = active-high.
REQ-011 SHALL have port irq_line  input  VBITS  line-compare value.
REQ-012 SHALL have ports hsync, vsync, blank, border  output  1 each  video_bus timing signals.
REQ-013 SHALL have ports hctr  output  HBITS and vctr  output  VBITS  current beam position.
REQ-014 SHALL have ports frame_start  output  1 and irq  output  1  single-cycle pulses.

Function
REQ-015 SHALL, on a cycle with pix_ce=1, increment hctr; at hctr==h_total-1 wrap hctr to 0 and increment vctr; at vctr==v_total-1 with hctr wrap, wrap vctr to 0.
REQ-016 SHALL hold all counters and outputs unchanged on cycles with pix_ce=0.
REQ-017 SHALL register hsync/vsync/blank/border from the counter values, one pix_ce-qualified cycle of latency relative to hctr/vctr.
REQ-018 SHALL define display region as hctr<h_disp and vctr<v_disp; border region as hctr<h_bdr_end and vctr<v_bdr_end but not display; blank=1 outside the display region; border=1 only in the border region.
REQ-019 SHALL assert hsync (at hsync_pol level) for h_sync_start<=hctr<h_sync_end, otherwise the inverse level; vsync likewise with vctr and v fields.
REQ-020 SHALL latch cfg_h/cfg_v/cfg_total/cfg_pol into a shadow set on cfg_we=1, regardless of pix_ce.
REQ-021 SHALL copy shadow to the active set only on the pix_ce cycle where both counters wrap to (0,0); mid-frame writes never alter current-frame timing.
REQ-022 SHALL, when cfg_we and the frame wrap coincide, load the previous shadow contents into the active set; the new write takes effect one frame later.
REQ-023 SHALL pulse frame_start for one clk on the pix_ce cycle where counters become (0,0).
REQ-024 SHALL treat h_total or v_total below 2 as 2 (clamp) to prevent counter lockup.
REQ-025 SHALL not check field ordering; inconsistent values (e.g. h_disp>h_total) produce defined but meaningless signals, no lockup.

Reset
REQ-026 SHALL, on rst=1 at clk edge: hctr=0, vctr=0, blank=1, border=0, frame_start=0, irq=0, hsync/vsync at inactive level of the reset polarity.
REQ-027 SHALL reset active and shadow sets to 640x480 defaults: h_disp 640, h_bdr_end 648, h_sync 656..752, h_total 800; v_disp 480, v_bdr_end 485, v_sync 490..492, v_total 525; both polarities 0 (active-low).
REQ-028 SHALL let rst override pix_ce and cfg_we; a cfg_we on the reset cycle is discarded.

Configuration
REQ-029 SHALL, with macro VIDEO_TIMING_CTRL_LINE_IRQ_EN defined, pulse irq for one clk on the pix_ce cycle where hctr becomes 0 and the new vctr equals irq_line; irq_line sampled live (no shadowing).
REQ-030 SHALL, without VIDEO_TIMING_CTRL_LINE_IRQ_EN, drive irq constant 0, ignore irq_line, and generate no compare logic.

Verification
REQ-031 SHALL cover reset defaults, pix_ce=1 continuous: frame_start period 800*525=420000 clk; hsync low hctr 656..751; vsync low lines 490..491.
REQ-032 SHALL cover pix_ce asserted every other clk: frame_start period 840000 clk, outputs held steady on pix_ce=0 cycles.
REQ-033 SHALL cover mid-frame cfg_we (h_total 100, v_total 10) at vctr=200: current frame unchanged, next frame period 1000 pix_ce cycles.
REQ-034 SHALL cover cfg_we coincident with frame wrap: new timing first seen at following frame_start.
REQ-035 SHALL cover border: at vctr=100, border=1 exactly for hctr 640..647, blank=1 for hctr 640..799 (one-cycle registered latency).
REQ-036 SHALL cover, with VIDEO_TIMING_CTRL_LINE_IRQ_EN and irq_line=479: one irq pulse per frame at (0,479); rst asserted mid-frame returns to REQ-026 values next clk.
